// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: command encoding and the slave-port FSM states.
package xbar_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } slv_state_e;

endpackage

// File: rtl/xbar_slave_port_if.sv
// Bundle of master-side fan-in and slave-side signals around one slave port.
// The slave modport is the port logic's view; master is the surrounding
// environment (master fan-in plus the attached slave).
interface xbar_slave_port_if #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int SLV_ADDR_W  = 31
);
  logic [NUM_MASTERS-1:0]        master_req;
  logic [NUM_MASTERS-1:0]        master_cmd;
  logic [NUM_MASTERS*ADDR_W-1:0] master_addr;
  logic [NUM_MASTERS*DATA_W-1:0] master_wdata;
  logic [NUM_MASTERS-1:0]        ack_o;
  logic [NUM_MASTERS-1:0]        err_o;
  logic [NUM_MASTERS-1:0]        rvalid_o;
  logic [DATA_W-1:0]             rdata_o;
  logic                          req;
  logic                          cmd;
  logic [SLV_ADDR_W-1:0]         addr;
  logic [DATA_W-1:0]             wdata;
  logic                          ack_i;
  logic [DATA_W-1:0]             rdata_i;

  modport slave (
    input  master_req, master_cmd, master_addr, master_wdata, ack_i, rdata_i,
    output ack_o, err_o, rvalid_o, rdata_o, req, cmd, addr, wdata
  );

  modport master (
    output master_req, master_cmd, master_addr, master_wdata, ack_i, rdata_i,
    input  ack_o, err_o, rvalid_o, rdata_o, req, cmd, addr, wdata
  );
endinterface

// File: rtl/xbar_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester found searching
// upward from ptr+1 (wrapping) wins.
module xbar_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_vec,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  // Rotating priority search; once a winner is found later candidates are masked off.
  always_comb begin : p_search
    int               cand_s;
    logic [IDX_W-1:0] cand_idx_s;
    logic             hit_s;
    cand_s     = 0;
    cand_idx_s = '0;
    hit_s      = 1'b0;
    gnt_oh     = '0;
    gnt_idx    = '0;
    gnt_vld    = 1'b0;
    for (int off = 1; off <= N; off++) begin
      cand_s          = (int'(ptr) + off) % N;
      cand_idx_s      = IDX_W'(cand_s);
      hit_s           = !gnt_vld && req_vec[cand_idx_s];
      gnt_oh[cand_idx_s] = gnt_oh[cand_idx_s] | hit_s;
      gnt_idx         = hit_s ? cand_idx_s : gnt_idx;
      gnt_vld         = gnt_vld | hit_s;
    end
  end

endmodule

// File: rtl/xbar_slave_port.sv
// Slave-side crossbar port: round-robin grant among masters, one transaction
// at a time to the slave, ack/err/read data routed back to the granted master.
module xbar_slave_port
  import xbar_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int SLV_ADDR_W  = 31,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  xbar_slave_port_if.slave  bus
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  slv_state_e              state_r, state_s;
  logic [IDX_W-1:0]        ptr_r, ptr_s;
  logic [NUM_MASTERS-1:0]  gnt_oh_r, gnt_oh_s;
  logic                    cmd_r, cmd_s;
  logic [SLV_ADDR_W-1:0]   addr_r, addr_s;
  logic [DATA_W-1:0]       wdata_r, wdata_s;
  logic                    req_r, req_s;
  logic [NUM_MASTERS-1:0]  ack_r, ack_s;
  logic [NUM_MASTERS-1:0]  err_r, err_s;
  logic [NUM_MASTERS-1:0]  rvalid_r, rvalid_s;
  logic [DATA_W-1:0]       rdata_r, rdata_s;
  logic [CNT_W-1:0]        rd_cnt_r, rd_cnt_s;
  logic [TO_W-1:0]         to_cnt_r, to_cnt_s;

  logic [NUM_MASTERS-1:0]  elig_s;
  logic [NUM_MASTERS-1:0]  arb_oh_s;
  logic [IDX_W-1:0]        arb_idx_s;
  logic                    arb_vld_s;

  // A master acknowledged this cycle may still hold its request; keep it out.
  assign elig_s = bus.master_req & ~ack_r;

  xbar_rr_arbiter #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_arb (
    .req_vec (elig_s),
    .ptr     (ptr_r),
    .gnt_oh  (arb_oh_s),
    .gnt_idx (arb_idx_s),
    .gnt_vld (arb_vld_s)
  );

  // Next-state and next-output logic; pulse outputs default low every cycle.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    gnt_oh_s = gnt_oh_r;
    cmd_s    = cmd_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    req_s    = req_r;
    ack_s    = '0;
    err_s    = '0;
    rvalid_s = '0;
    rdata_s  = rdata_r;
    rd_cnt_s = rd_cnt_r;
    to_cnt_s = to_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (arb_vld_s) begin
          gnt_oh_s = arb_oh_s;
          ptr_s    = arb_idx_s;
          cmd_s    = bus.master_cmd[arb_idx_s];
          addr_s   = bus.master_addr[int'(arb_idx_s)*ADDR_W +: SLV_ADDR_W];
          wdata_s  = bus.master_wdata[int'(arb_idx_s)*DATA_W +: DATA_W];
          req_s    = 1'b1;
          to_cnt_s = '0;
          state_s  = ST_ISSUE;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.ack_i) begin
          req_s = 1'b0;
          ack_s = gnt_oh_r;
          if (cmd_r == CMD_WRITE) begin
            state_s = ST_IDLE;
          end else begin
            rd_cnt_s = CNT_W'(RD_LAT);
            state_s  = ST_WAIT_RD;
          end
        end else if ((TIMEOUT > 0) && (to_cnt_r == TO_W'(TIMEOUT - 1))) begin
          req_s   = 1'b0;
          ack_s   = gnt_oh_r;
          err_s   = gnt_oh_r;
          state_s = ST_IDLE;
        end else begin
          to_cnt_s = to_cnt_r + TO_W'(1);
        end
      end
      ST_WAIT_RD: begin
        // Counter reaches 1 in exactly the cycle the slave drives valid data.
        if (rd_cnt_r == CNT_W'(1)) begin
          rdata_s  = bus.rdata_i;
          rvalid_s = gnt_oh_r;
          state_s  = ST_IDLE;
        end else begin
          rd_cnt_s = rd_cnt_r - CNT_W'(1);
        end
      end
      default: begin
        req_s   = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Registered datapath and outputs; pointer resets so master 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r    <= IDX_W'(NUM_MASTERS - 1);
      gnt_oh_r <= '0;
      cmd_r    <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      req_r    <= 1'b0;
      ack_r    <= '0;
      err_r    <= '0;
      rvalid_r <= '0;
      rdata_r  <= '0;
      rd_cnt_r <= '0;
      to_cnt_r <= '0;
    end else begin
      ptr_r    <= ptr_s;
      gnt_oh_r <= gnt_oh_s;
      cmd_r    <= cmd_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      req_r    <= req_s;
      ack_r    <= ack_s;
      err_r    <= err_s;
      rvalid_r <= rvalid_s;
      rdata_r  <= rdata_s;
      rd_cnt_r <= rd_cnt_s;
      to_cnt_r <= to_cnt_s;
    end
  end

  assign bus.req      = req_r;
  assign bus.cmd      = cmd_r;
  assign bus.addr     = addr_r;
  assign bus.wdata    = wdata_r;
  assign bus.ack_o    = ack_r;
  assign bus.err_o    = err_r;
  assign bus.rvalid_o = rvalid_r;
  assign bus.rdata_o  = rdata_r;

endmodule

// File: tb/tb_xbar_slave_port.sv
// Scoreboard bench for xbar_slave_port: directed stimulus queues the expected
// slave issues, acks and read returns with their cycle numbers; a negedge
// monitor pops and compares whenever the DUT presents one.
module tb_xbar_slave_port;
  import xbar_pkg::*;

  localparam int NM  = 4;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SAW = 31;
  localparam int RDL = 1;
  localparam int TO  = 4;

  localparam int K_ISSUE = 0;
  localparam int K_ACK   = 1;
  localparam int K_RV    = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xbar_slave_port_if #(.NUM_MASTERS(NM), .DATA_W(DW), .ADDR_W(AW), .SLV_ADDR_W(SAW)) bus ();

  xbar_slave_port #(
    .NUM_MASTERS(NM), .DATA_W(DW), .ADDR_W(AW), .SLV_ADDR_W(SAW),
    .RD_LAT(RDL), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int            kind;
    int            cyc;
    logic [NM-1:0] vec;
    logic [NM-1:0] err;
    logic          cmd;
    logic [SAW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [NM-1:0] vec,
                      input logic [NM-1:0] err, input logic cmd,
                      input logic [SAW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    e.kind = kind; e.cyc = c; e.vec = vec; e.err = err;
    e.cmd = cmd; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic mon_event(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, expected nothing", kind, cyc);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
      case (kind)
        K_ISSUE: begin
          check("issue_cmd", bus.cmd, e.cmd);
          check("issue_addr", bus.addr, e.addr);
          check("issue_wdata", bus.wdata, e.data);
        end
        K_ACK: begin
          check("ack_o", bus.ack_o, e.vec);
          check("err_o", bus.err_o, e.err);
          check("req_low_at_ack", bus.req, 1'b0);
        end
        default: begin
          check("rvalid_o", bus.rvalid_o, e.vec);
          check("rdata_o", bus.rdata_o, e.data);
        end
      endcase
    end
  endtask

  // Monitor: sample away from the active edge, one expectation per DUT event.
  logic req_q = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req && !req_q) mon_event(K_ISSUE);
      if (bus.ack_o != '0)   mon_event(K_ACK);
      if (bus.rvalid_o != '0) mon_event(K_RV);
    end
    req_q <= bus.req;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic cmd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.master_cmd[m]              = cmd;
    bus.master_addr[m*AW +: AW]    = a;
    bus.master_wdata[m*DW +: DW]   = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst              = 1'b1;
    bus.master_req   = '0;
    bus.master_cmd   = '0;
    bus.master_addr  = '0;
    bus.master_wdata = '0;
    bus.ack_i        = 1'b0;
    bus.rdata_i      = 32'hBAD0_0000;
    tick(3);
    check("rst_req", bus.req, 1'b0);
    check("rst_ack_o", bus.ack_o, 4'b0000);
    check("rst_err_o", bus.err_o, 4'b0000);
    check("rst_rvalid_o", bus.rvalid_o, 4'b0000);
    check("rst_rdata_o", bus.rdata_o, 32'h0);
    check("rst_addr", bus.addr, 31'h0);
    rst = 1'b0;
    tick(2);

    // Single write from master 0; slave acks two cycles after req rises.
    c = cyc;
    set_m(0, CMD_WRITE, 32'h8000_0010, 32'h1234_5678);
    bus.master_req = 4'b0001;
    push(K_ISSUE, c + 1, 4'b0000, 4'b0000, CMD_WRITE, 31'h0000_0010, 32'h1234_5678);
    tick(3);
    push(K_ACK, c + 4, 4'b0001, 4'b0000, 1'b0, 31'h0, 32'h0);
    bus.ack_i = 1'b1;
    tick(1);
    bus.ack_i = 1'b0;
    tick(1);
    bus.master_req = 4'b0000;
    tick(2);

    // Single read from master 1, RD_LAT=1; garbage on rdata_i except the valid cycle.
    c = cyc;
    set_m(1, CMD_READ, 32'h0000_0040, 32'h5555_AAAA);
    bus.master_req = 4'b0010;
    push(K_ISSUE, c + 1, 4'b0000, 4'b0000, CMD_READ, 31'h0000_0040, 32'h5555_AAAA);
    tick(1);
    bus.ack_i = 1'b1;
    push(K_ACK, c + 2, 4'b0010, 4'b0000, 1'b0, 31'h0, 32'h0);
    tick(1);
    bus.ack_i   = 1'b0;
    bus.rdata_i = 32'hDEAD_BEEF;
    push(K_RV, c + 3, 4'b0010, 4'b0000, 1'b0, 31'h0, 32'hDEAD_BEEF);
    tick(1);
    bus.rdata_i    = 32'hBAD0_0000;
    bus.master_req = 4'b0000;
    tick(3);
    check("rdata_hold", bus.rdata_o, 32'hDEAD_BEEF);
    check("rvalid_idle", bus.rvalid_o, 4'b0000);

    // Masters 0 and 1 hold writes continuously; pointer sits at 1 so 0 goes first.
    set_m(0, CMD_WRITE, 32'h0000_0100, 32'hA0A0_0000);
    set_m(1, CMD_WRITE, 32'h0000_0200, 32'hB1B1_0000);
    c = cyc;
    bus.master_req = 4'b0011;
    bus.ack_i      = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        push(K_ISSUE, c + 1 + 2*k, 4'b0000, 4'b0000, CMD_WRITE, 31'h0000_0100, 32'hA0A0_0000);
        push(K_ACK,   c + 2 + 2*k, 4'b0001, 4'b0000, 1'b0, 31'h0, 32'h0);
      end else begin
        push(K_ISSUE, c + 1 + 2*k, 4'b0000, 4'b0000, CMD_WRITE, 31'h0000_0200, 32'hB1B1_0000);
        push(K_ACK,   c + 2 + 2*k, 4'b0010, 4'b0000, 1'b0, 31'h0, 32'h0);
      end
    end
    tick(8);
    bus.master_req = 4'b0000;
    bus.ack_i      = 1'b0;
    tick(2);

    // Grant master 2, then masters 1 and 3 request: 3 must precede 1.
    set_m(2, CMD_WRITE, 32'h0000_0300, 32'hC2C2_0000);
    c = cyc;
    bus.master_req = 4'b0100;
    bus.ack_i      = 1'b1;
    push(K_ISSUE, c + 1, 4'b0000, 4'b0000, CMD_WRITE, 31'h0000_0300, 32'hC2C2_0000);
    push(K_ACK,   c + 2, 4'b0100, 4'b0000, 1'b0, 31'h0, 32'h0);
    tick(2);
    set_m(1, CMD_WRITE, 32'h0000_0210, 32'hB1B1_0001);
    set_m(3, CMD_WRITE, 32'h0000_0330, 32'hD3D3_0000);
    bus.master_req = 4'b1010;
    push(K_ISSUE, c + 3, 4'b0000, 4'b0000, CMD_WRITE, 31'h0000_0330, 32'hD3D3_0000);
    push(K_ACK,   c + 4, 4'b1000, 4'b0000, 1'b0, 31'h0, 32'h0);
    push(K_ISSUE, c + 5, 4'b0000, 4'b0000, CMD_WRITE, 31'h0000_0210, 32'hB1B1_0001);
    push(K_ACK,   c + 6, 4'b0010, 4'b0000, 1'b0, 31'h0, 32'h0);
    tick(2);
    bus.master_req = 4'b0010;
    tick(2);
    bus.master_req = 4'b0000;
    bus.ack_i      = 1'b0;
    tick(2);

    // Read from master 2 that the slave never acks: timeout after 4 ISSUE cycles.
    set_m(2, CMD_READ, 32'h0000_0400, 32'h0000_0000);
    c = cyc;
    bus.master_req = 4'b0100;
    push(K_ISSUE, c + 1, 4'b0000, 4'b0000, CMD_READ, 31'h0000_0400, 32'h0000_0000);
    push(K_ACK,   c + 5, 4'b0100, 4'b0100, 1'b0, 31'h0, 32'h0);
    tick(5);
    bus.master_req = 4'b0000;
    tick(2);

    // Next request proceeds; ack arrives on the last cycle before timeout.
    set_m(0, CMD_WRITE, 32'h0000_0500, 32'hE0E0_0000);
    c = cyc;
    bus.master_req = 4'b0001;
    push(K_ISSUE, c + 1, 4'b0000, 4'b0000, CMD_WRITE, 31'h0000_0500, 32'hE0E0_0000);
    tick(4);
    bus.ack_i = 1'b1;
    push(K_ACK, c + 5, 4'b0001, 4'b0000, 1'b0, 31'h0, 32'h0);
    tick(1);
    bus.ack_i      = 1'b0;
    bus.master_req = 4'b0000;
    tick(2);

    // Reset while a read from master 1 sits in WAIT_RD.
    set_m(1, CMD_READ, 32'h0000_0600, 32'h0000_0000);
    c = cyc;
    bus.master_req = 4'b0010;
    push(K_ISSUE, c + 1, 4'b0000, 4'b0000, CMD_READ, 31'h0000_0600, 32'h0000_0000);
    tick(1);
    bus.ack_i = 1'b1;
    tick(1);
    bus.ack_i      = 1'b0;
    bus.rdata_i    = 32'h7777_7777;
    rst            = 1'b1;
    bus.master_req = 4'b0000;
    #1;
    check("rst_mid_ack_o", bus.ack_o, 4'b0000);
    check("rst_mid_rvalid_o", bus.rvalid_o, 4'b0000);
    check("rst_mid_req", bus.req, 1'b0);
    check("rst_mid_rdata_o", bus.rdata_o, 32'h0);
    check("rst_mid_addr", bus.addr, 31'h0);
    tick(2);
    check("rst_hold_rvalid_o", bus.rvalid_o, 4'b0000);
    rst         = 1'b0;
    bus.rdata_i = 32'hBAD0_0000;
    tick(2);

    // After reset masters 0 and 1 request together: master 0 first.
    set_m(0, CMD_WRITE, 32'h0000_0700, 32'h7070_0000);
    set_m(1, CMD_WRITE, 32'h0000_0710, 32'h7171_0000);
    c = cyc;
    bus.master_req = 4'b0011;
    bus.ack_i      = 1'b1;
    push(K_ISSUE, c + 1, 4'b0000, 4'b0000, CMD_WRITE, 31'h0000_0700, 32'h7070_0000);
    push(K_ACK,   c + 2, 4'b0001, 4'b0000, 1'b0, 31'h0, 32'h0);
    push(K_ISSUE, c + 3, 4'b0000, 4'b0000, CMD_WRITE, 31'h0000_0710, 32'h7171_0000);
    push(K_ACK,   c + 4, 4'b0010, 4'b0000, 1'b0, 31'h0, 32'h0);
    tick(4);
    bus.master_req = 4'b0000;
    bus.ack_i      = 1'b0;
    tick(3);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
